// File: rtl/constants.sv
// Shared types and helpers for the label emitter: FSM encoding, delimiter and
// the 5-bit letter code to ASCII mapping.
package constants;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        OPEN,
        LETTERS,
        CLOSE,
        DONE,
        MISS
    } label_emitter_state_t;

    localparam logic [7:0] LABEL_DELIM = 8'h2E;

    // Codes are already lowercase-folded at capture, so the mapping is a fixed prefix.
    function automatic logic [7:0] label_code_to_ascii(input logic [4:0] code);
        return {3'b011, code};
    endfunction

endpackage

// File: rtl/label_table.sv
// Shift-in label table: new entries enter at index 0, the oldest falls off the end.
// A single indexed read port lets the searcher walk one entry per cycle.
module label_table #(
    parameter int unsigned NUMBER_LETTERS = 6,
    parameter int unsigned NUM_LABELS     = 8,
    parameter int unsigned PCW            = 10,
    parameter int unsigned IDXW           = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [NUMBER_LETTERS-1:0][4:0] wr_label,
    input  logic [PCW-1:0]                 wr_pc,
    input  logic [IDXW-1:0]                rd_idx,
    output logic                           rd_valid,
    output logic [NUMBER_LETTERS-1:0][4:0] rd_label,
    output logic [PCW-1:0]                 rd_pc
);

    logic                           valid_q [NUM_LABELS];
    logic [NUMBER_LETTERS-1:0][4:0] label_q [NUM_LABELS];
    logic [PCW-1:0]                 pc_q    [NUM_LABELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                valid_q[i] <= 1'b0;
                label_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (wr_en) begin
            valid_q[0] <= 1'b1;
            label_q[0] <= wr_label;
            pc_q[0]    <= wr_pc;
            for (int i = 1; i < NUM_LABELS; i++) begin
                valid_q[i] <= valid_q[i-1];
                label_q[i] <= label_q[i-1];
                pc_q[i]    <= pc_q[i-1];
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_label = label_q[rd_idx];
    assign rd_pc    = pc_q[rd_idx];

endmodule

// File: rtl/label_emitter.sv
// Looks up the label bound to a branch target PC and streams ".name." out one
// ASCII character per accepted handshake.
module label_emitter
    import constants::*;
#(
    parameter int unsigned NUMBER_LINES   = 256,
    parameter int unsigned NUMBER_LETTERS = 6,
    parameter int unsigned NUM_LABELS     = 8,
    localparam int unsigned PCW           = $clog2(NUMBER_LINES) + 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           wr_en,
    input  logic [NUMBER_LETTERS-1:0][4:0] wr_label,
    input  logic [PCW-1:0]                 wr_pc,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [PCW-1:0]                 req_pc,
    input  logic [31:0]                    req_offset,
    output logic                           char_valid_out,
    input  logic                           char_ready_in,
    output logic [7:0]                     char_out,
    output logic                           last_out,
    output logic                           done_flag,
    output logic                           miss_flag
);

    localparam int unsigned IDXW = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
    localparam int unsigned SLW  = (NUMBER_LETTERS > 1) ? $clog2(NUMBER_LETTERS) : 1;

    label_emitter_state_t           state;
    logic [IDXW-1:0]                idx;
    logic [SLW-1:0]                 slot;
    logic [SLW-1:0]                 hi_slot;
    logic [PCW-1:0]                 target;
    logic [NUMBER_LETTERS-1:0][4:0] label_q;
    logic                           rd_valid;
    logic [NUMBER_LETTERS-1:0][4:0] rd_label;
    logic [PCW-1:0]                 rd_pc;
    logic                           unused_offset;

    // Only the low PCW bits matter: the target wraps modulo 2^PCW.
    assign unused_offset = ^req_offset[31:PCW];

    label_table #(
        .NUMBER_LETTERS(NUMBER_LETTERS),
        .NUM_LABELS    (NUM_LABELS),
        .PCW           (PCW),
        .IDXW          (IDXW)
    ) u_label_table (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_label(wr_label),
        .wr_pc   (wr_pc),
        .rd_idx  (idx),
        .rd_valid(rd_valid),
        .rd_label(rd_label),
        .rd_pc   (rd_pc)
    );

    always_comb begin
        hi_slot = '0;
        for (int i = 0; i < NUMBER_LETTERS; i++) begin
            if (label_q[i] != 5'd0) hi_slot = SLW'(i);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            idx            <= '0;
            slot           <= '0;
            target         <= '0;
            label_q        <= '0;
            req_ready      <= 1'b1;
            char_valid_out <= 1'b0;
            char_out       <= '0;
            last_out       <= 1'b0;
            done_flag      <= 1'b0;
            miss_flag      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        target    <= req_pc + req_offset[PCW-1:0];
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Index 0 is the newest entry, so the first hit is the newest binding.
                    if (rd_valid && (rd_pc == target)) begin
                        label_q        <= rd_label;
                        char_valid_out <= 1'b1;
                        char_out       <= LABEL_DELIM;
                        last_out       <= 1'b0;
                        state          <= OPEN;
                    end else if (idx == IDXW'(NUM_LABELS - 1)) begin
                        miss_flag <= 1'b1;
                        state     <= MISS;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OPEN: begin
                    if (char_ready_in) begin
                        if (label_q == '0) begin
                            char_out <= LABEL_DELIM;
                            last_out <= 1'b1;
                            state    <= CLOSE;
                        end else begin
                            slot     <= hi_slot;
                            char_out <= label_code_to_ascii(label_q[hi_slot]);
                            state    <= LETTERS;
                        end
                    end
                end
                LETTERS: begin
                    if (char_ready_in) begin
                        if (slot == '0) begin
                            char_out <= LABEL_DELIM;
                            last_out <= 1'b1;
                            state    <= CLOSE;
                        end else begin
                            slot     <= slot - 1'b1;
                            char_out <= label_code_to_ascii(label_q[slot - 1'b1]);
                        end
                    end
                end
                CLOSE: begin
                    if (char_ready_in) begin
                        char_valid_out <= 1'b0;
                        char_out       <= '0;
                        last_out       <= 1'b0;
                        done_flag      <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    done_flag <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                MISS: begin
                    miss_flag <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
